dmi_regbus_bridge: RTL and testbench

//  Core-side DMI endpoint; sits directly downstream of the DMI clock-domain crossing FIFO.

---
 rtl/dmi_regbus_bridge.sv | 181 ++++++++++++++++++
 tb/tb_dmi_regbus_bridge.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_regbus_bridge.sv
// dmi_regbus_bridge
//   Core-side DMI endpoint. Takes one DMI request at a time from the CDC FIFO
//   read side, performs a single transfer on a req/gnt/rvalid register bus and
//   returns exactly one DMI response per request. Bus errors and the reserved
//   op map to resp=2 (failed). With DMI_BRIDGE_TIMEOUT_EN defined, a transfer
//   that does not complete within TimeoutCycles of entering REQ is aborted with
//   resp=2.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   dmi_req_i/_valid_i/_ready_o  request {addr, op, data}; ready = idle
//   dmi_resp_o/_valid_o/_ready_i response {data, resp}
//   reg_req_o/_we_o/_addr_o/_wdata_o   bus request side, held until reg_gnt_i
//   reg_gnt_i/_rvalid_i/_rdata_i/_err_i bus grant and completion
//   busy_o                       high whenever the bridge is not idle
//
// Optional feature macro: DMI_BRIDGE_TIMEOUT_EN (bus timeout abort).
module dmi_regbus_bridge #(
  parameter int unsigned AddrWidth     = 7,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [AddrWidth+DataWidth+1:0] dmi_req_i,
  input  logic                           dmi_req_valid_i,
  output logic                           dmi_req_ready_o,
  output logic [DataWidth+1:0]           dmi_resp_o,
  output logic                           dmi_resp_valid_o,
  input  logic                           dmi_resp_ready_i,
  output logic                           reg_req_o,
  output logic                           reg_we_o,
  output logic [AddrWidth-1:0]           reg_addr_o,
  output logic [DataWidth-1:0]           reg_wdata_o,
  input  logic                           reg_gnt_i,
  input  logic                           reg_rvalid_i,
  input  logic [DataWidth-1:0]           reg_rdata_i,
  input  logic                           reg_err_i,
  output logic                           busy_o
);

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] RESP_OK  = 2'd0;
  localparam logic [1:0] RESP_ERR = 2'd2;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [1:0]           op;
    logic [DataWidth-1:0] data;
  } req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
  } resp_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e state_q, state_d;
  req_t   req;
  resp_t  resp_q, resp_d;
  logic   resp_load;
  logic   accept;
  logic   expire;

  assign req             = req_t'(dmi_req_i);
  assign dmi_req_ready_o = (state_q == IDLE);
  assign dmi_resp_o      = resp_q;

`ifdef DMI_BRIDGE_TIMEOUT_EN
  // Counter is held at zero outside REQ/WAIT, so it is zero in the first REQ
  // cycle and expiry lands TimeoutCycles cycles after REQ entry.
  localparam int unsigned CntW = $clog2(TimeoutCycles);
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else if (state_q == REQ || state_q == WAIT) cnt_q <= cnt_q + CntW'(1);
    else cnt_q <= '0;
  end

  assign expire = (state_q == REQ || state_q == WAIT) &&
                  (cnt_q == CntW'(TimeoutCycles - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TimeoutCycles != 0);
  assign expire         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    resp_d    = '0;
    resp_load = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dmi_req_valid_i) begin
          accept = 1'b1;
          if (req.op == OP_READ || req.op == OP_WRITE) begin
            state_d = REQ;
          end else begin
            // NOP succeeds, reserved op fails; neither touches the bus.
            state_d   = RESP;
            resp_load = 1'b1;
            resp_d    = '{data: '0, resp: (req.op == OP_NOP) ? RESP_OK : RESP_ERR};
          end
        end
      end
      REQ: begin
        // Zero-wait slave completes in the grant cycle; completion beats expiry.
        if (reg_gnt_i && reg_rvalid_i) begin
          state_d   = RESP;
          resp_load = 1'b1;
          resp_d    = '{data: (!reg_we_o && !reg_err_i) ? reg_rdata_i : '0,
                        resp: reg_err_i ? RESP_ERR : RESP_OK};
        end else if (expire) begin
          state_d   = RESP;
          resp_load = 1'b1;
          resp_d    = '{data: '0, resp: RESP_ERR};
        end else if (reg_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (reg_rvalid_i) begin
          state_d   = RESP;
          resp_load = 1'b1;
          resp_d    = '{data: (!reg_we_o && !reg_err_i) ? reg_rdata_i : '0,
                        resp: reg_err_i ? RESP_ERR : RESP_OK};
        end else if (expire) begin
          state_d   = RESP;
          resp_load = 1'b1;
          resp_d    = '{data: '0, resp: RESP_ERR};
        end
      end
      RESP: begin
        if (dmi_resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Handshake-style outputs are registered copies of the next state, so they
  // line up with the state they describe without any combinational path.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_req_o        <= 1'b0;
      dmi_resp_valid_o <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      reg_req_o        <= (state_d == REQ);
      dmi_resp_valid_o <= (state_d == RESP);
      busy_o           <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_we_o    <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
    end else if (accept) begin
      reg_we_o    <= (req.op == OP_WRITE);
      reg_addr_o  <= req.addr;
      reg_wdata_o <= (req.op == OP_WRITE) ? req.data : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          resp_q <= '0;
    else if (resp_load) resp_q <= resp_d;
  end

endmodule

// File: tb/tb_dmi_regbus_bridge.sv
// tb_dmi_regbus_bridge
//   Directed plus randomized transfers against dmi_regbus_bridge. The bench
//   plays the CDC source/sink and the register-bus slave, and predicts each
//   DMI response and its timing from the op/err/rdata of the transfer.
module tb_dmi_regbus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [40:0] dmi_req;
  logic        dmi_req_valid;
  logic        dmi_req_ready;
  logic [33:0] dmi_resp;
  logic        dmi_resp_valid;
  logic        dmi_resp_ready;
  logic        reg_req;
  logic        reg_we;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_gnt;
  logic        reg_rvalid;
  logic [31:0] reg_rdata;
  logic        reg_err;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmi_regbus_bridge #(.AddrWidth(7), .DataWidth(32), .TimeoutCycles(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .dmi_req_i(dmi_req), .dmi_req_valid_i(dmi_req_valid), .dmi_req_ready_o(dmi_req_ready),
    .dmi_resp_o(dmi_resp), .dmi_resp_valid_o(dmi_resp_valid), .dmi_resp_ready_i(dmi_resp_ready),
    .reg_req_o(reg_req), .reg_we_o(reg_we), .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata),
    .reg_gnt_i(reg_gnt), .reg_rvalid_i(reg_rvalid), .reg_rdata_i(reg_rdata), .reg_err_i(reg_err),
    .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {data, resp} from the op and the slave's completion.
  function automatic logic [33:0] model(input logic [1:0] op, input logic err,
                                        input logic [31:0] rdata);
    case (op)
      2'd0:    return {32'h0, 2'd0};
      2'd1:    return err ? {32'h0, 2'd2} : {rdata, 2'd0};
      2'd2:    return {32'h0, err ? 2'd2 : 2'd0};
      default: return {32'h0, 2'd2};
    endcase
  endfunction

  // One complete DMI transaction. Inputs change on negedges; outputs are read
  // on negedges. gnt_dly: REQ cycles before grant; rv_dly: cycles from grant
  // to rvalid (0 = same cycle); stall: cycles the sink holds ready low.
  task automatic xfer(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata,
                      input int gnt_dly, input int rv_dly, input logic err,
                      input logic [31:0] rdata, input int stall);
    logic [33:0] exp;
    bit bus;
    bus = (op == 2'd1 || op == 2'd2);
    exp = model(op, err, rdata);
    @(negedge clk);
    chk("req_ready_idle", {63'h0, dmi_req_ready}, 64'h1);
    dmi_req       = {addr, op, wdata};
    dmi_req_valid = 1'b1;
    @(negedge clk);
    dmi_req_valid = 1'b0;
    dmi_req       = {$urandom, $urandom} & 64'h1ff_ffff_ffff;
    chk("req_ready_busy", {63'h0, dmi_req_ready}, 64'h0);
    chk("busy", {63'h0, busy}, 64'h1);
    if (bus) begin
      chk("reg_req_first", {63'h0, reg_req}, 64'h1);
      chk("reg_we", {63'h0, reg_we}, {63'h0, op == 2'd2});
      chk("reg_addr", {57'h0, reg_addr}, {57'h0, addr});
      if (op == 2'd2) chk("reg_wdata", {32'h0, reg_wdata}, {32'h0, wdata});
      for (int i = 0; i < gnt_dly; i++) begin
        chk("reg_req_held", {63'h0, reg_req}, 64'h1);
        // A completion strobe without grant must be ignored.
        reg_rvalid = 1'($urandom_range(0, 1));
        reg_rdata  = $urandom;
        reg_err    = 1'($urandom_range(0, 1));
        @(negedge clk);
        reg_rvalid = 1'b0;
      end
      chk("reg_req_at_gnt", {63'h0, reg_req}, 64'h1);
      chk("no_resp_in_req", {63'h0, dmi_resp_valid}, 64'h0);
      reg_gnt    = 1'b1;
      reg_rvalid = (rv_dly == 0);
      reg_rdata  = rdata;
      reg_err    = err;
      @(negedge clk);
      reg_gnt    = 1'b0;
      reg_rvalid = 1'b0;
      if (rv_dly > 0) begin
        for (int i = 0; i < rv_dly; i++) begin
          chk("reg_req_dropped", {63'h0, reg_req}, 64'h0);
          chk("no_resp_in_wait", {63'h0, dmi_resp_valid}, 64'h0);
          reg_rdata = $urandom;
          reg_err   = 1'($urandom_range(0, 1));
          if (i == rv_dly - 1) begin
            reg_rvalid = 1'b1;
            reg_rdata  = rdata;
            reg_err    = err;
          end
          @(negedge clk);
          reg_rvalid = 1'b0;
        end
      end
    end else begin
      chk("no_bus_req", {63'h0, reg_req}, 64'h0);
    end
    chk("resp_valid", {63'h0, dmi_resp_valid}, 64'h1);
    chk("resp_payload", {30'h0, dmi_resp}, {30'h0, exp});
    chk("reg_req_idle_in_resp", {63'h0, reg_req}, 64'h0);
    for (int i = 0; i < stall; i++) begin
      // Stray strobe while responding must not disturb anything.
      reg_rvalid = 1'($urandom_range(0, 1));
      reg_rdata  = $urandom;
      @(negedge clk);
      reg_rvalid = 1'b0;
      chk("stall_valid", {63'h0, dmi_resp_valid}, 64'h1);
      chk("stall_payload", {30'h0, dmi_resp}, {30'h0, exp});
      chk("stall_req_ready", {63'h0, dmi_req_ready}, 64'h0);
    end
    dmi_resp_ready = 1'b1;
    @(negedge clk);
    dmi_resp_ready = 1'b0;
    chk("resp_done", {63'h0, dmi_resp_valid}, 64'h0);
    chk("idle_again", {63'h0, dmi_req_ready}, 64'h1);
    chk("not_busy", {63'h0, busy}, 64'h0);
  endtask

  initial begin
    rst            = 1'b1;
    dmi_req        = '0;
    dmi_req_valid  = 1'b0;
    dmi_resp_ready = 1'b0;
    reg_gnt        = 1'b0;
    reg_rvalid     = 1'b0;
    reg_rdata      = '0;
    reg_err        = 1'b0;
    #12;
    chk("rst_req_ready", {63'h0, dmi_req_ready}, 64'h1);
    chk("rst_resp_valid", {63'h0, dmi_resp_valid}, 64'h0);
    chk("rst_resp", {30'h0, dmi_resp}, 64'h0);
    chk("rst_reg_req", {63'h0, reg_req}, 64'h0);
    chk("rst_reg_we", {63'h0, reg_we}, 64'h0);
    chk("rst_reg_addr", {57'h0, reg_addr}, 64'h0);
    chk("rst_reg_wdata", {32'h0, reg_wdata}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait read, delayed write, errored read, NOP, reserved op.
    xfer(2'd1, 7'h11, 32'h0, 0, 0, 1'b0, 32'hCAFE_F00D, 0);
    xfer(2'd2, 7'h10, 32'h1, 3, 2, 1'b0, 32'hDEAD_BEEF, 0);
    xfer(2'd1, 7'h04, 32'h0, 1, 1, 1'b1, 32'h1234_5678, 0);
    xfer(2'd0, 7'h00, 32'h5555_AAAA, 0, 0, 1'b0, 32'h0, 0);
    xfer(2'd3, 7'h22, 32'h0, 0, 0, 1'b0, 32'h0, 0);
    xfer(2'd2, 7'h7f, 32'hFFFF_FFFF, 0, 0, 1'b1, 32'h0, 0);
    // Response backpressure.
    xfer(2'd1, 7'h33, 32'h0, 2, 0, 1'b0, 32'hA5A5_5A5A, 5);

    // Reset while waiting for rvalid abandons the transfer.
    @(negedge clk);
    dmi_req = {7'h12, 2'd1, 32'h0}; dmi_req_valid = 1'b1;
    @(negedge clk);
    dmi_req_valid = 1'b0;
    reg_gnt = 1'b1;
    @(negedge clk);
    reg_gnt = 1'b0;
    chk("wait_entered", {63'h0, reg_req}, 64'h0);
    rst = 1'b1;
    #1;
    chk("midrst_resp_valid", {63'h0, dmi_resp_valid}, 64'h0);
    chk("midrst_req_ready", {63'h0, dmi_req_ready}, 64'h1);
    chk("midrst_busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    reg_rvalid = 1'b1; reg_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    reg_rvalid = 1'b0;
    chk("late_rvalid_no_resp", {63'h0, dmi_resp_valid}, 64'h0);
    chk("late_rvalid_idle", {63'h0, dmi_req_ready}, 64'h1);
    xfer(2'd1, 7'h12, 32'h0, 0, 1, 1'b0, 32'h600D_600D, 0);

`ifdef DMI_BRIDGE_TIMEOUT_EN
    // Grant never arrives: abort 8 cycles after REQ entry.
    @(negedge clk);
    dmi_req = {7'h05, 2'd1, 32'h0}; dmi_req_valid = 1'b1;
    @(negedge clk);
    dmi_req_valid = 1'b0;
    chk("to_req_entry", {63'h0, reg_req}, 64'h1);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk("to_req_held", {63'h0, reg_req}, 64'h1);
      chk("to_no_resp", {63'h0, dmi_resp_valid}, 64'h0);
    end
    @(negedge clk);
    chk("to_req_drop", {63'h0, reg_req}, 64'h0);
    chk("to_resp_valid", {63'h0, dmi_resp_valid}, 64'h1);
    chk("to_resp", {30'h0, dmi_resp}, {30'h0, 32'h0, 2'd2});
    dmi_resp_ready = 1'b1;
    @(negedge clk);
    dmi_resp_ready = 1'b0;
    chk("to_idle", {63'h0, dmi_req_ready}, 64'h1);
`endif

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      xfer(2'($urandom_range(0, 3)), 7'($urandom), $urandom,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
